bcd_operand_entry: RTL and testbench

//  Upstream stage of the 2-digit BCD adder: captures operands X, Y and carry-in from board

---
 rtl/bcd_pkg.sv | 17 +
 rtl/key_debounce.sv | 65 ++++++
 rtl/bcd_operand_entry.sv | 90 +++++++++
 tb/tb_bcd_operand_entry.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the BCD adder operand-entry stage.
//   PH_*     phase encodings, also driven onto the status LEDs
//   BCD_MAX  largest digit accepted at entry time
//   is_bcd() digit range check used by the entry FSM
package bcd_pkg;

    localparam logic [1:0] PH_ENTER_X = 2'b00;
    localparam logic [1:0] PH_ENTER_Y = 2'b01;
    localparam logic [1:0] PH_READY   = 2'b10;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchroniser, debounce counter and press-pulse generator for an
// active-low pushbutton.
//   clk    in  1  rising-edge clock
//   rst    in  1  synchronous active-high reset
//   key_n  in  1  raw pushbutton, active-low, asynchronous to clk
//   press  out 1  one-cycle pulse on each debounced 1->0 transition
// Latency from a stable key_n edge to press: 2 + DEBOUNCE_CYCLES cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;  // last accepted key level
    logic             armed;   // a debounced release has been seen since reset
    logic [CNT_W-1:0] cnt;

    // NOTE: all state here is updated with non-blocking assignments so the
    // two synchroniser flops really form a two-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            armed  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (!armed) begin
                // After reset a key that is already held down must first be
                // released (and debounced) before it can produce a press, so
                // an interrupted bounce never completes into a pulse.
                if (!sync2) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (sync2 == stable) begin
                // Any return to the accepted level restarts the count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;  // only the falling (pressed) edge emits
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: captures X, Y and carry-in for the 2-digit BCD adder, one
// digit per debounced key press, rejecting digits above 9.
//   clk            in  1  rising-edge clock
//   rst            in  1  synchronous active-high reset
//   key_n          in  1  raw pushbutton, active-low
//   clr            in  1  synchronous clear of the entry FSM and outputs
//   sw_digit       in  4  digit switches
//   sw_cin         in  1  carry-in switch
//   X, Y           out 4  latched BCD operands
//   cin            out 1  latched carry-in
//   operands_valid out 1  high while in READY
//   entry_err      out 1  high after a rejected digit
//   phase          out 2  entry phase (status LEDs)
module bcd_operand_entry
    import bcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       clr,
    input  logic [3:0] sw_digit,
    input  logic       sw_cin,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       cin,
    output logic       operands_valid,
    output logic       entry_err,
    output logic [1:0] phase
);

    logic press;

    // The debouncer sees only rst: clr restarts the entry, not the key path.
    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (rst || clr || phase == 2'b11) begin
            X              <= 4'd0;
            Y              <= 4'd0;
            cin            <= 1'b0;
            operands_valid <= 1'b0;
            entry_err      <= 1'b0;
            phase          <= PH_ENTER_X;
        end else if (press) begin
            case (phase)
                PH_ENTER_X: begin
                    if (is_bcd(sw_digit)) begin
                        X         <= sw_digit;
                        entry_err <= 1'b0;
                        phase     <= PH_ENTER_Y;
                    end else begin
                        entry_err <= 1'b1;
                    end
                end
                PH_ENTER_Y: begin
                    if (is_bcd(sw_digit)) begin
                        Y              <= sw_digit;
                        cin            <= sw_cin;
                        entry_err      <= 1'b0;
                        operands_valid <= 1'b1;
                        phase          <= PH_READY;
                    end else begin
                        entry_err <= 1'b1;
                    end
                end
                default: begin
                    // READY: a press starts a fresh entry.
                    X              <= 4'd0;
                    Y              <= 4'd0;
                    cin            <= 1'b0;
                    operands_valid <= 1'b0;
                    entry_err      <= 1'b0;
                    phase          <= PH_ENTER_X;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_operand_entry.sv
module tb_bcd_operand_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] sw_digit = 4'd0;
    logic       sw_cin = 1'b0;
    logic [3:0] X;
    logic [3:0] Y;
    logic       cin;
    logic       operands_valid;
    logic       entry_err;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    bcd_operand_entry #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_n          (key_n),
        .clr            (clr),
        .sw_digit       (sw_digit),
        .sw_cin         (sw_cin),
        .X              (X),
        .Y              (Y),
        .cin            (cin),
        .operands_valid (operands_valid),
        .entry_err      (entry_err),
        .phase          (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit before driving inputs.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full press/release cycle with generous debounce margins.
    task automatic press_key(input logic [3:0] d, input logic c);
        sw_digit = d;
        sw_cin   = c;
        key_n    = 1'b0;
        step(10);
        key_n = 1'b1;
        step(10);
    endtask

    initial begin
        // 1 Reset
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_X", 8'(X), 8'd0);
        check("rst_Y", 8'(Y), 8'd0);
        check("rst_cin", 8'(cin), 8'd0);
        check("rst_valid", 8'(operands_valid), 8'd0);
        check("rst_err", 8'(entry_err), 8'd0);
        check("rst_phase", 8'(phase), 8'd0);
        step(10);

        // 2 Entry: X=7, then Y=5 with cin=1; valid one cycle after the press pulse
        press_key(4'd7, 1'b0);
        @(negedge clk);
        check("entry_X", 8'(X), 8'd7);
        check("entry_phase_y", 8'(phase), 8'd1);
        sw_digit = 4'd5;
        sw_cin   = 1'b1;
        key_n    = 1'b0;
        step(6);
        @(negedge clk);
        check("entry_pulse_phase", 8'(phase), 8'd1);
        check("entry_pulse_valid", 8'(operands_valid), 8'd0);
        step(1);
        @(negedge clk);
        check("ready_phase", 8'(phase), 8'd2);
        check("ready_valid", 8'(operands_valid), 8'd1);
        check("ready_X", 8'(X), 8'd7);
        check("ready_Y", 8'(Y), 8'd5);
        check("ready_cin", 8'(cin), 8'd1);
        step(1);
        key_n = 1'b1;
        step(10);
        // Switch changes in READY without a press are ignored
        sw_digit = 4'd9;
        sw_cin   = 1'b0;
        step(3);
        @(negedge clk);
        check("frozen_Y", 8'(Y), 8'd5);
        check("frozen_cin", 8'(cin), 8'd1);

        // 5a Restart from READY
        press_key(4'd8, 1'b0);
        @(negedge clk);
        check("restart_X", 8'(X), 8'd0);
        check("restart_Y", 8'(Y), 8'd0);
        check("restart_valid", 8'(operands_valid), 8'd0);
        check("restart_phase", 8'(phase), 8'd0);

        // 3 Invalid digit in ENTER_X, then a valid one
        press_key(4'd12, 1'b0);
        @(negedge clk);
        check("bad_err", 8'(entry_err), 8'd1);
        check("bad_phase", 8'(phase), 8'd0);
        check("bad_X", 8'(X), 8'd0);
        press_key(4'd3, 1'b0);
        @(negedge clk);
        check("good_err", 8'(entry_err), 8'd0);
        check("good_X", 8'(X), 8'd3);
        check("good_phase", 8'(phase), 8'd1);

        // 5b clr concurrent with a press in ENTER_Y
        press_key(4'd12, 1'b1);
        @(negedge clk);
        check("bady_err", 8'(entry_err), 8'd1);
        check("bady_phase", 8'(phase), 8'd1);
        sw_digit = 4'd4;
        sw_cin   = 1'b1;
        key_n    = 1'b0;
        step(5);
        clr = 1'b1;       // covers the edge that consumes the press pulse
        step(3);
        clr = 1'b0;
        @(negedge clk);
        check("clr_phase", 8'(phase), 8'd0);
        check("clr_X", 8'(X), 8'd0);
        check("clr_err", 8'(entry_err), 8'd0);
        check("clr_valid", 8'(operands_valid), 8'd0);
        key_n = 1'b1;
        step(10);
        @(negedge clk);
        check("clr_after_phase", 8'(phase), 8'd0);

        // 4 Bounce: 10 toggles every 2 cycles, then hold low
        sw_digit = 4'd2;
        sw_cin   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_n = ~key_n;
            step(2);
        end
        @(negedge clk);
        check("bounce_nopress", 8'(phase), 8'd0);
        key_n = 1'b0;
        step(6);
        @(negedge clk);
        check("bounce_early", 8'(phase), 8'd0);
        step(1);
        @(negedge clk);
        check("bounce_press", 8'(phase), 8'd1);
        check("bounce_X", 8'(X), 8'd2);
        step(100);
        @(negedge clk);
        check("hold_norepeat", 8'(phase), 8'd1);
        key_n = 1'b1;
        step(10);

        // 6 Reset mid-debounce with the key held low
        sw_digit = 4'd6;
        key_n    = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("middb_phase", 8'(phase), 8'd0);
        check("middb_X", 8'(X), 8'd0);
        step(30);
        @(negedge clk);
        check("middb_nopress", 8'(phase), 8'd0);
        key_n = 1'b1;
        step(10);
        press_key(4'd6, 1'b0);
        @(negedge clk);
        check("middb_repress_phase", 8'(phase), 8'd1);
        check("middb_repress_X", 8'(X), 8'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
